// File: rtl/player_controller.sv
// Game sequencer: debounces the three move switches into one-shot requests,
// commits one move per video frame and runs the PLAY/WIN/DEAD state machine.
module player_controller #(
    parameter int GRID_W           = 20,
    parameter int GRID_H           = 15,
    parameter int START_X          = 10,
    parameter int START_Y          = 14,
    parameter int ARRIVAL_Y        = 0,
    parameter int DEBOUNCE_CYCLES  = 250000,
    parameter int WIN_HOLD_FRAMES  = 60,
    parameter int DEAD_HOLD_FRAMES = 90,
    parameter int MAX_LEVEL        = 99
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Switch_1,
    input  logic       i_Switch_2,
    input  logic       i_Switch_3,
    input  logic       i_Frame_Start,
    input  logic       i_Collision,
    output logic [9:0] o_Player_X,
    output logic [9:0] o_Player_Y,
    output logic [6:0] o_Level,
    output logic [1:0] o_State,
    output logic       o_Level_Up
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [9:0]    START_X_V   = 10'(START_X);
    localparam logic [9:0]    START_Y_V   = 10'((START_Y > GRID_H - 1) ? GRID_H - 1 : START_Y);
    localparam logic [9:0]    LAST_X_V    = 10'(GRID_W - 1);
    localparam logic [9:0]    ARRIVAL_V   = 10'(ARRIVAL_Y);
    localparam logic [6:0]    MAX_LEVEL_V = 7'(MAX_LEVEL);
    localparam logic [7:0]    WIN_HOLD_V  = 8'(WIN_HOLD_FRAMES);
    localparam logic [7:0]    DEAD_HOLD_V = 8'(DEAD_HOLD_FRAMES);
    localparam logic [CW-1:0] DB_LAST_V   = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_WIN  = 2'd1,
        ST_DEAD = 2'd2,
        ST_BAD  = 2'd3
    } state_t;

    // Bit 0 = up, bit 1 = left, bit 2 = right throughout.
    logic [2:0]    raw_s, sync1_r, sync2_r, db_r, db_prev_r, edge_s;
    logic [CW-1:0] cnt_r [3];
    logic [2:0]    pending_r, pending_s;
    state_t        state_r, state_s;
    logic [9:0]    x_r, x_s, y_r, y_s;
    logic [6:0]    level_r, level_s;
    logic          level_up_r, level_up_s;
    logic [7:0]    frame_cnt_r, frame_cnt_s;

    function automatic logic [6:0] next_level(input logic [6:0] lv);
        return (lv == MAX_LEVEL_V) ? 7'd0 : lv + 7'd1;
    endfunction

    assign raw_s  = {i_Switch_3, i_Switch_2, i_Switch_1};
    assign edge_s = db_r & ~db_prev_r;

    // Synchronise and debounce each switch.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync1_r   <= 3'b000;
            sync2_r   <= 3'b000;
            db_r      <= 3'b000;
            db_prev_r <= 3'b000;
            for (int i = 0; i < 3; i++) cnt_r[i] <= '0;
        end else begin
            sync1_r   <= raw_s;
            sync2_r   <= sync1_r;
            db_prev_r <= db_r;
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i] == db_r[i]) begin
                    cnt_r[i] <= '0;
                end else if (cnt_r[i] == DB_LAST_V) begin
                    db_r[i]  <= sync2_r[i];
                    cnt_r[i] <= '0;
                end else begin
                    cnt_r[i] <= cnt_r[i] + CW'(1);
                end
            end
        end
    end

    // Requests raised on the frame-start cycle survive until the next frame.
    always_comb begin
        pending_s = pending_r;
        if (i_Frame_Start) begin
            pending_s = (state_r == ST_PLAY) ? edge_s : 3'b000;
        end else if (state_r == ST_PLAY) begin
            pending_s = pending_r | edge_s;
        end else begin
            pending_s = pending_r;
        end
    end

    // Next-state, position and level update.
    always_comb begin
        state_s     = state_r;
        x_s         = x_r;
        y_s         = y_r;
        level_s     = level_r;
        level_up_s  = 1'b0;
        frame_cnt_s = frame_cnt_r;
        case (state_r)
            ST_PLAY: begin
                if (!i_Frame_Start) begin
                    state_s = ST_PLAY;
                end else if (i_Collision) begin
                    state_s     = ST_DEAD;
                    level_s     = 7'd0;
                    frame_cnt_s = 8'd0;
                end else begin
                    if (pending_r[0]) begin
                        y_s = (y_r == 10'd0) ? 10'd0 : y_r - 10'd1;
                    end else if (pending_r[1]) begin
                        x_s = (x_r == 10'd0) ? 10'd0 : x_r - 10'd1;
                    end else if (pending_r[2]) begin
                        x_s = (x_r == LAST_X_V) ? LAST_X_V : x_r + 10'd1;
                    end else begin
                        x_s = x_r;
                    end
                    if (y_s == ARRIVAL_V) begin
                        state_s     = ST_WIN;
                        level_up_s  = 1'b1;
                        level_s     = next_level(level_r);
                        frame_cnt_s = 8'd0;
                    end else begin
                        state_s = ST_PLAY;
                    end
                end
            end
            ST_WIN, ST_DEAD: begin
                if (i_Frame_Start) begin
                    frame_cnt_s = frame_cnt_r + 8'd1;
                    if (frame_cnt_s == ((state_r == ST_WIN) ? WIN_HOLD_V : DEAD_HOLD_V)) begin
                        x_s     = START_X_V;
                        y_s     = START_Y_V;
                        state_s = ST_PLAY;
                    end else begin
                        state_s = state_r;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_BAD:  state_s = ST_PLAY;
            default: state_s = ST_PLAY;
        endcase
    end

    // Game state registers.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_r     <= ST_PLAY;
            x_r         <= START_X_V;
            y_r         <= START_Y_V;
            level_r     <= 7'd0;
            level_up_r  <= 1'b0;
            frame_cnt_r <= 8'd0;
            pending_r   <= 3'b000;
        end else begin
            state_r     <= state_s;
            x_r         <= x_s;
            y_r         <= y_s;
            level_r     <= level_s;
            level_up_r  <= level_up_s;
            frame_cnt_r <= frame_cnt_s;
            pending_r   <= pending_s;
        end
    end

    assign o_Player_X = x_r;
    assign o_Player_Y = y_r;
    assign o_Level    = level_r;
    assign o_State    = state_r;
    assign o_Level_Up = level_up_r;

endmodule
